// File: rtl/cnt_pwm_if.sv
// -----------------------------------------------------------------------------
// cnt_pwm_if -- duty-update handshake between a duty requester and cnt_pwm.
//
// Signals
//   duty_in   requested PWM high time, in cycles per period (W bits)
//   duty_vld  duty_in is valid; the requester holds it until duty_rdy is seen
//   duty_rdy  cnt_pwm shadow register is free (no duty update pending)
//
// Modports
//   master  requester side: drives duty_in/duty_vld, observes duty_rdy
//   slave   cnt_pwm side:   observes duty_in/duty_vld, drives duty_rdy
// -----------------------------------------------------------------------------
interface cnt_pwm_if #(
   parameter int W = 8
);
   logic [W-1:0] duty_in;
   logic         duty_vld;
   logic         duty_rdy;

   modport master (
      output duty_in,
      output duty_vld,
      input  duty_rdy
   );

   modport slave (
      input  duty_in,
      input  duty_vld,
      output duty_rdy
   );
endinterface

// File: rtl/cnt_pwm.sv
// -----------------------------------------------------------------------------
// cnt_pwm -- PWM generator framed by an upstream free-running W-bit counter.
//
// The block samples the upstream count every cycle, verifies that it steps by
// exactly one (modulo 2^W), locks onto the 255->0 style boundary to frame
// 2^W-cycle PWM periods, and drives a registered PWM output. The duty cycle is
// requested through a valid/ready port, held in a shadow register and only
// promoted to the active duty at a period boundary, so a period is never
// produced with a mixture of two duty values.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   res        asynchronous reset, active low
//   cnt        upstream count, valid every cycle
//   duty       duty handshake (cnt_pwm_if.slave): duty_in / duty_vld / duty_rdy
//   err_clr    single-cycle clear, honoured only while in the error state
//   pwm        registered PWM output
//   wrap       one-cycle pulse per detected period boundary
//   frame_cnt  number of periods completed while running (wraps mod 2^FW)
//   err        sticky count-sequence error
// -----------------------------------------------------------------------------
module cnt_pwm #(
   parameter int W  = 8,
   parameter int FW = 16
) (
   input  logic          clk,
   input  logic          res,
   input  logic [W-1:0]  cnt,
   cnt_pwm_if.slave      duty,
   input  logic          err_clr,
   output logic          pwm,
   output logic          wrap,
   output logic [FW-1:0] frame_cnt,
   output logic          err
);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [W-1:0] CNT_MAX  = '1;
   localparam logic [W-1:0] CNT_ZERO = '0;

   state_t       state;
   logic [W-1:0] cnt_d;
   logic         cnt_d_vld;
   logic [W-1:0] shadow;
   logic         pend;
   logic [W-1:0] duty_act;

   logic         wrap_hit;
   logic         seq_ok;
   logic         accept;
   logic         apply;
   logic [W-1:0] duty_eff;
   logic         pwm_next;

   // True when cur is the modulo-2^W successor of prev; the W-bit add wraps
   // on its own, so 255 -> 0 is a legal step.
   function automatic logic is_successor(input logic [W-1:0] cur,
                                         input logic [W-1:0] prev);
      return cur == W'(prev + W'(1));
   endfunction

   // ---- sample stage: decode the incoming count against the delayed copy ----
   assign wrap_hit = cnt_d_vld & (cnt == CNT_ZERO) & (cnt_d == CNT_MAX);
   assign seq_ok   = ~cnt_d_vld | is_successor(cnt, cnt_d);

   // A pending shadow value is promoted on the boundary cycle itself, so the
   // new duty already governs cnt=0 of the period it belongs to. An accept
   // can only happen with pend=0 and a promotion only with pend=1, so the two
   // never collide: a value accepted on a boundary waits for the next one.
   assign accept   = duty.duty_vld & ~pend;
   assign apply    = wrap_hit & pend & (state != ERR);
   assign duty_eff = apply ? shadow : duty_act;
   assign pwm_next = (cnt < duty_eff);

   assign duty.duty_rdy = ~pend;

   // ---- output stage: FSM, duty buffering and registered outputs ----
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= SYNC;
         cnt_d     <= '0;
         cnt_d_vld <= 1'b0;
         shadow    <= '0;
         pend      <= 1'b0;
         duty_act  <= '0;
         pwm       <= 1'b0;
         wrap      <= 1'b0;
         frame_cnt <= '0;
         err       <= 1'b0;
      end else begin
         cnt_d     <= cnt;
         cnt_d_vld <= 1'b1;

         if (apply) begin
            duty_act <= shadow;
            pend     <= 1'b0;
         end
         if (accept) begin
            shadow <= duty.duty_in;
            pend   <= 1'b1;
         end

         case (state)
            SYNC: begin
               // Sequence errors are not tracked until the first boundary is
               // seen; that boundary starts a driven period but is not counted.
               wrap <= wrap_hit;
               if (wrap_hit) begin
                  state <= RUN;
                  pwm   <= pwm_next;
               end else begin
                  pwm <= 1'b0;
               end
            end

            RUN: begin
               if (!seq_ok) begin
                  state <= ERR;
                  err   <= 1'b1;
                  pwm   <= 1'b0;
                  wrap  <= 1'b0;
               end else begin
                  pwm  <= pwm_next;
                  wrap <= wrap_hit;
                  if (wrap_hit) begin
                     frame_cnt <= frame_cnt + FW'(1);
                  end
               end
            end

            ERR: begin
               pwm  <= 1'b0;
               wrap <= 1'b0;
               if (err_clr) begin
                  state     <= SYNC;
                  err       <= 1'b0;
                  frame_cnt <= '0;
               end
            end

            default: begin
               state <= SYNC;
               pwm   <= 1'b0;
               wrap  <= 1'b0;
            end
         endcase
      end
   end

endmodule
